// File: rtl/clock_domain_pkg.sv
// Shared types for the source-side toggle req/ack clock-domain exporter.
package clock_domain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } clock_domain_export_state_t;

endpackage

// File: rtl/clock_domain_export_if.sv
// Word-input and handshake bundle of clock_domain_export.
// Optional CLOCK_DOMAIN_EXPORT_LEVEL_EN adds the FIFO occupancy signal `level`.
interface clock_domain_export_if #(
  parameter int SIZE = 8
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
  , parameter int DEPTH = 4
`endif
);
  logic [SIZE-1:0] data;
  logic            stb;
  logic            ready;
  logic [SIZE-1:0] handshake_data;
  logic            handshake_req;
  logic            handshake_ack;
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
  logic [$clog2(DEPTH):0] level;

  modport master (output data, stb, handshake_ack,
                  input  ready, handshake_data, handshake_req, level);
  modport slave  (input  data, stb, handshake_ack,
                  output ready, handshake_data, handshake_req, level);
`else
  modport master (output data, stb, handshake_ack,
                  input  ready, handshake_data, handshake_req);
  modport slave  (input  data, stb, handshake_ack,
                  output ready, handshake_data, handshake_req);
`endif
endinterface

// File: rtl/clock_domain_export_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// Optional CLOCK_DOMAIN_EXPORT_LEVEL_EN exposes occupancy (wptr - rptr).
module clock_domain_export_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [SIZE-1:0] din,
  output logic            full,
  output logic            empty,
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
  output logic [$clog2(DEPTH):0] level,
`endif
  output logic [SIZE-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign empty = wptr == rptr;
  assign head  = mem[rptr[AW-1:0]];
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
  assign level = wptr - rptr;
`endif

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/clock_domain_export.sv
// Source half of a toggle req/ack CDC: buffers words, launches one per req toggle.
// Optional CLOCK_DOMAIN_EXPORT_LEVEL_EN drives bus.level with FIFO occupancy.
module clock_domain_export
  import clock_domain_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  clock_domain_export_if.slave bus
);
  clock_domain_export_state_t state;
  logic [1:0]      ack_ff;
  logic            ack_s;
  logic            req_q;
  logic [SIZE-1:0] data_q;
  logic            full;
  logic            empty;
  logic [SIZE-1:0] head;
  logic            launch;

  assign ack_s  = ack_ff[0];
  // Matching ack also gates the first launch after reset, absorbing a stale high ack.
  assign launch = (state == IDLE) && !empty && (ack_s == req_q);

  clock_domain_export_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.stb),
    .pop   (launch),
    .din   (bus.data),
    .full  (full),
    .empty (empty),
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
    .level (bus.level),
`endif
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      data_q <= '0;
      ack_ff <= 2'b00;
    end else begin
      ack_ff <= {bus.handshake_ack, ack_ff[1]};
      case (state)
        IDLE: begin
          if (launch) begin
            data_q <= head;
            state  <= LOAD;
          end
        end
        LOAD: begin
          req_q <= ~req_q;
          state <= WAIT;
        end
        WAIT: begin
          if (ack_s == req_q) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready          = !full;
  assign bus.handshake_data = data_q;
  assign bus.handshake_req  = req_q;
endmodule

// File: tb/tb_clock_domain_export.sv
// Self-checking bench for clock_domain_export with a behavioural importer model.
// Define CLOCK_DOMAIN_EXPORT_LEVEL_EN to also check the occupancy output.
module tb_clock_domain_export;
  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_domain_export_if #(.SIZE(SIZE)
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
    , .DEPTH(DEPTH)
`endif
  ) bus ();

  clock_domain_export #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Importer model: ack echoes req after ack_delay clocks, or is forced.
  int          ack_delay     = 2;
  bit          ack_force     = 1'b1;
  logic        ack_force_val = 1'b0;
  logic [15:0] req_hist      = '0;

  always @(negedge clk) begin
    req_hist = {req_hist[14:0], bus.handshake_req};
    if (ack_force) bus.handshake_ack = ack_force_val;
    else           bus.handshake_ack = req_hist[ack_delay];
  end

  // Receiver: captures a word per req toggle; data must have been stable a clock earlier.
  logic       last_req   = 1'b0;
  logic [7:0] prev_hdata = '0;
  int         toggles    = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      last_req = 1'b0;
    end else if (bus.handshake_req !== last_req) begin
      check("data_setup", bus.handshake_data, prev_hdata);
      rx_q.push_back(bus.handshake_data);
      toggles++;
      last_req = bus.handshake_req;
    end
    prev_hdata = bus.handshake_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_scoreboard();
    rx_q.delete();
    exp_q.delete();
    toggles = 0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.stb = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_scoreboard();
  endtask

  task automatic send(input logic [7:0] d, input int budget);
    bit acc;
    acc = 1'b0;
    bus.data = d;
    bus.stb  = 1'b1;
    for (int i = 0; i < budget && !acc; i++) begin
      acc = bus.ready;
      tick();
    end
    bus.stb = 1'b0;
    if (acc) exp_q.push_back(d);
    else     check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_toggles(input int n, input int budget, input string name);
    for (int i = 0; i < budget && toggles < n; i++) tick();
    check(name, toggles, n);
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check({name, "_word"}, rx_q[i], exp_q[i]);
  endtask

  typedef struct packed {
    logic       stb;
    logic [7:0] data;
    logic       exp_ready;
    logic [7:0] exp_hdata;
    logic       exp_req;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
    for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1};

    bus.stb  = 1'b0;
    bus.data = '0;

    // Reset release with ack held low.
    do_reset();
    check("rst_ready", bus.ready, 1'b1);
    check("rst_req", bus.handshake_req, 1'b0);
    check("rst_data", bus.handshake_data, 8'h00);
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
    check("rst_level", bus.level, 0);
`endif
    repeat (20) tick();
    check("rst_no_toggle", toggles, 0);

    // Single word latency, table-driven.
    ack_force = 1'b0;
    ack_delay = 2;
    for (int i = 0; i < 10; i++) begin
      bus.stb  = tbl[i].stb;
      bus.data = tbl[i].data;
      if (tbl[i].stb && bus.ready) exp_q.push_back(tbl[i].data);
      tick();
      bus.stb = 1'b0;
      check("tbl_ready", bus.ready, tbl[i].exp_ready);
      check("tbl_hdata", bus.handshake_data, tbl[i].exp_hdata);
      check("tbl_req", bus.handshake_req, tbl[i].exp_req);
    end
    check("single_toggles", toggles, 1);
    send(8'h5A, 20);
    wait_toggles(2, 50, "after_ack_idle");
    compare_queues("single");
    repeat (10) tick();

    // Burst of 6 with slow ack: FIFO fills while word 1 is in flight.
    ack_delay = 6;
    repeat (20) tick();
    clear_scoreboard();
    for (int w = 1; w <= 6; w++) begin
      send(w[7:0], 200);
      if (w == 5) check("burst_full_ready", bus.ready, 1'b0);
    end
    wait_toggles(6, 500, "burst_toggles");
    compare_queues("burst");
    repeat (20) tick();

    // Ack never returns.
    ack_force     = 1'b1;
    ack_force_val = bus.handshake_ack;
    clear_scoreboard();
    send(8'h11, 20);
    wait_toggles(1, 50, "stuck_first");
    for (int w = 0; w < 4; w++) send(8'h21 + w[7:0], 20);
    check("stuck_ready", bus.ready, 1'b0);
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
    check("stuck_level", bus.level, 4);
`endif
    bus.stb  = 1'b1;
    bus.data = 8'h99;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stuck_hdata", bus.handshake_data, 8'h11);
    end
    bus.stb = 1'b0;
    check("stuck_toggles", toggles, 1);

    // Reset while in WAIT with ack high; ack drops 5 clocks later.
    do_reset();
    ack_force_val = 1'b0;
    send(8'h77, 20);
    wait_toggles(1, 50, "rw_launch");
    ack_force_val = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_scoreboard();
    check("rw_req", bus.handshake_req, 1'b0);
    check("rw_ready", bus.ready, 1'b1);
    check("rw_hdata", bus.handshake_data, 8'h00);
`ifdef CLOCK_DOMAIN_EXPORT_LEVEL_EN
    check("rw_level", bus.level, 0);
`endif
    tick();
    tick();
    send(8'h3C, 5);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rw_hold_hdata", bus.handshake_data, 8'h00);
    end
    ack_force_val = 1'b0;
    tick();
    check("rw_sync1", bus.handshake_data, 8'h00);
    tick();
    check("rw_sync2", bus.handshake_data, 8'h00);
    tick();
    check("rw_load", bus.handshake_data, 8'h3C);
    check("rw_load_req", bus.handshake_req, 1'b0);
    tick();
    check("rw_toggle", bus.handshake_req, 1'b1);
    ack_force = 1'b0;
    ack_delay = 1;
    wait_toggles(1, 20, "rw_toggle_count");
    compare_queues("rw");
    repeat (20) tick();

    // Randomized traffic: concurrent push/pop and pointer wrap.
    do_reset();
    ack_force = 1'b0;
    for (int chunk = 0; chunk < 3; chunk++) begin
      int sent;
      int total;
      ack_delay = $urandom_range(1, 5);
      repeat (20) tick();
      sent  = 0;
      total = exp_q.size() + 15;
      for (int cyc = 0; cyc < 2000 && sent < 15; cyc++) begin
        bit acc;
        bus.stb  = ($urandom_range(0, 1) == 1);
        bus.data = 8'($urandom);
        acc = bus.stb && bus.ready;
        if (acc) begin
          exp_q.push_back(bus.data);
          sent++;
        end
        tick();
      end
      bus.stb = 1'b0;
      wait_toggles(total, 1000, "rand_toggles");
    end
    compare_queues("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
